vote_session_ctrl: RTL

- Sequences one four-voter ballot session: arms on start, latches each voter's first ballot, closes on all-cast or timeout, then tallies.
- Result uses the existing one-hot encoding O[3:1]: 100 approve, 010 tie, 001 reject.
- Sits between voter push-button/strobe logic and the result display; owns session timing and the once-per-voter rule.

---
 rtl/vote_session_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vote_session_ctrl.sv
// Four-voter ballot session controller.
// Opens a session on start, latches the first ballot from each voter, and
// closes once all four have voted or the collection window expires. It then
// tallies the yes votes into a one-hot result and holds that result for the
// display until ack arrives or the hold window runs out.
module vote_session_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int HOLD    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cast,
    input  logic [3:0] ballot,
    input  logic       ack,
    output logic       busy,
    output logic [3:0] voted,
    output logic [2:0] yes_cnt,
    output logic [3:1] O,
    output logic       valid
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

    localparam logic [3:1] RESULT_APPROVE = 3'b100;
    localparam logic [3:1] RESULT_TIE     = 3'b010;
    localparam logic [3:1] RESULT_REJECT  = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        TALLY,
        SHOW
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      yes_reg;
    logic [TW-1:0]   timer;
    logic [HW-1:0]   hold_cnt;
    logic [3:0]      new_votes;
    logic [3:0]      yes_masked;
    logic            all_cast;
    logic            timeout_hit;
    logic            hold_done;
    logic [3:1]      tally_result;

    // Session events derived from the current registers and this cycle's strobes.
    always_comb begin
        new_votes   = cast & ~voted;
        all_cast    = ((voted | cast) == 4'b1111);
        timeout_hit = (timer == TIMER_LAST);
        hold_done   = (hold_cnt == HOLD_LAST);
        yes_masked  = yes_reg & voted;
        yes_cnt     = 3'(yes_masked[0]) + 3'(yes_masked[1])
                    + 3'(yes_masked[2]) + 3'(yes_masked[3]);
    end

    // Map the yes count onto the one-hot approve / tie / reject result.
    always_comb begin
        tally_result = RESULT_REJECT;
        if (yes_cnt >= 3'd3) begin
            tally_result = RESULT_APPROVE;
        end else if (yes_cnt == 3'd2) begin
            tally_result = RESULT_TIE;
        end
    end

    // State register; reset abandons any session in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: all-cast and timeout both lead to TALLY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (all_cast || timeout_hit) begin
                    state_next = TALLY;
                end
            end
            TALLY: begin
                state_next = SHOW;
            end
            SHOW: begin
                if (ack || hold_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == SHOW);
    end

    // Ballot latching: only a voter's first strobe in a session is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            voted   <= 4'b0000;
            yes_reg <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        voted   <= 4'b0000;
                        yes_reg <= 4'b0000;
                    end
                end
                COLLECT: begin
                    voted   <= voted | new_votes;
                    yes_reg <= yes_reg | (new_votes & ballot);
                end
                SHOW: begin
                    if (state_next == IDLE) begin
                        voted   <= 4'b0000;
                        yes_reg <= 4'b0000;
                    end
                end
                default: begin
                    voted   <= voted;
                    yes_reg <= yes_reg;
                end
            endcase
        end
    end

    // Collection window timer, restarted each time a session opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                timer <= '0;
            end
        end else if (state == COLLECT) begin
            timer <= timer + 1'b1;
        end
    end

    // Result register and hold counter covering the TALLY and SHOW phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            O        <= 3'b000;
            hold_cnt <= '0;
        end else begin
            case (state)
                TALLY: begin
                    O        <= tally_result;
                    hold_cnt <= '0;
                end
                SHOW: begin
                    if (state_next == IDLE) begin
                        O        <= 3'b000;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    O        <= 3'b000;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
